// File: rtl/serial_sub_accum.sv
// serial_sub_accum
//   Bit-serial subtract-accumulator with its own run-once control. One Run press
//   subtracts the zero-extended Din operand from the accumulator. The subtraction
//   runs LSB first, one bit per clock. Holding Run does not start another
//   subtraction. Run must be released before the next press is accepted.
//
//   Optional feature macro: SUB_SATURATE_EN
//     defined   : on underflow the result is clamped to 0 in the Done cycle
//     undefined : two's-complement wrap
//     Borrow is 1 on underflow in both cases.
//
// Ports
//   Clk        in   1      system clock, rising edge
//   Reset      in   1      synchronous, active-high; overrides everything
//   Run        in   1      active-high subtract request
//   Load       in   1      active-high direct load of Acc from Din
//   Din        in   IN_W   operand, zero-extended to WIDTH
//   Acc        out  WIDTH  accumulator contents
//   Borrow     out  1      borrow out of the last subtraction (1 = underflow)
//   Busy       out  1      high while a subtraction is shifting
//   Done       out  1      one-cycle pulse in the first cycle after completion
//   state_dbg  out  2      current FSM state (0 IDLE, 1 SHIFT, 2 HOLD)
//
// Handshake: Run and Load are level requests sampled only in IDLE. A request
// is taken on the rising edge at which IDLE sees it. Done pulses exactly once
// per accepted Run. Done does not pulse for a Load.

module serial_sub_accum #(
    parameter int WIDTH = 16,
    parameter int IN_W  = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Load,
    input  logic [IN_W-1:0]  Din,
    output logic [WIDTH-1:0] Acc,
    output logic             Borrow,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       state_dbg
);

    // The counter must reach WIDTH itself. The cycle with cnt == WIDTH is the
    // completion step, in which Borrow is committed and no bit is shifted.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;     // latched operand, shifted right
    logic               c_q, c_d;         // running internal borrow
    logic               borrow_q, borrow_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic bit_a;
    logic bit_b;
    logic diff_bit;
    logic borrow_bit;

    // One full-subtractor slice: acc bit minus operand bit minus borrow-in.
    always_comb begin
        bit_a      = acc_q[0];
        bit_b      = opb_q[0];
        diff_bit   = bit_a ^ bit_b ^ c_q;
        borrow_bit = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & c_q);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        c_d      = c_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    // Load has priority over Run in the same cycle.
                    acc_d    = WIDTH'(Din);
                    borrow_d = 1'b0;
                    state_d  = ST_HOLD;
                end else if (Run) begin
                    opb_d   = WIDTH'(Din);
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = ST_HOLD;
                    borrow_d = c_q;
                    done_d   = 1'b1;
`ifdef SUB_SATURATE_EN
                    if (c_q) begin
                        acc_d = '0;
                    end
`endif
                end else begin
                    acc_d = {diff_bit, acc_q[WIDTH-1:1]};
                    opb_d = opb_q >> 1;
                    c_d   = borrow_bit;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                // Wait for both buttons to be released so that one press
                // gives exactly one operation.
                if (!Run && !Load) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            opb_q    <= '0;
            c_q      <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            c_q      <= c_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Acc       = acc_q;
    assign Borrow    = borrow_q;
    assign Busy      = (state_q == ST_SHIFT);
    assign Done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_sub_accum.sv
// Testbench for serial_sub_accum (WIDTH=16, IN_W=10).
// Directed vectors with hand-computed results. The stimulus pushes
// {borrow, acc} and the expected Done cycle into queues. A negedge monitor
// pops and compares them whenever Done is high.

module tb_serial_sub_accum;

  localparam int WIDTH = 16;
  localparam int IN_W  = 10;

`ifdef SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] UNDER_2_MINUS_5 = 16'h0000;
  localparam logic [WIDTH-1:0] UNDER_0_MINUS_10 = 16'h0000;
`else
  localparam logic [WIDTH-1:0] UNDER_2_MINUS_5 = 16'hFFFD;
  localparam logic [WIDTH-1:0] UNDER_0_MINUS_10 = 16'hFFF0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             load;
  logic [IN_W-1:0]  din;
  logic [WIDTH-1:0] acc;
  logic             borrow;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  serial_sub_accum #(.WIDTH(WIDTH), .IN_W(IN_W)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Run       (run),
    .Load      (load),
    .Din       (din),
    .Acc       (acc),
    .Borrow    (borrow),
    .Busy      (busy),
    .Done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  logic [WIDTH:0] exp_q[$];      // {borrow, acc}
  int             exp_cyc_q[$];  // cycle count at which Done must be seen

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [WIDTH:0] e;
    int             ec;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: Done high with no pending subtraction (cycle %0d, acc 0x%0h)", cyc, acc);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("done_acc", 32'(acc), 32'(e[WIDTH-1:0]));
        check("done_borrow", 32'(borrow), 32'(e[WIDTH]));
        check("done_latency", 32'(cyc), 32'(ec));
        check("done_busy_low", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    while (state_dbg !== 2'd0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(state_dbg), 32'd0);
  endtask

  task automatic do_load(input logic [IN_W-1:0] v);
    @(negedge clk);
    load = 1'b1;
    din  = v;
    @(negedge clk);
    load = 1'b0;
    check("load_acc", 32'(acc), 32'(v));
    check("load_borrow", 32'(borrow), 32'd0);
    wait_idle("load_to_idle");
  endtask

  task automatic do_run(input logic [IN_W-1:0] v, input int hold, input logic [WIDTH:0] exp);
    @(negedge clk);
    run = 1'b1;
    din = v;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 18);
    repeat (hold) @(negedge clk);
    run = 1'b0;
    wait_idle("run_to_idle");
  endtask

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    load  = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_acc", 32'(acc), 32'd0);
    check("reset_borrow", 32'(borrow), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // 5 - 3 = 2, no borrow
    do_load(10'h005);
    do_run(10'h003, 1, {1'b0, 16'h0002});

    // 2 - 5 underflows
    do_run(10'h005, 1, {1'b1, UNDER_2_MINUS_5});

    // Run and Load together in IDLE: load only, no subtraction
    d0 = done_cnt;
    @(negedge clk);
    run  = 1'b1;
    load = 1'b1;
    din  = 10'h3FF;
    @(negedge clk);
    run  = 1'b0;
    load = 1'b0;
    check("runload_acc", 32'(acc), 32'h03FF);
    check("runload_borrow", 32'(borrow), 32'd0);
    wait_idle("runload_to_idle");
    repeat (20) @(negedge clk);
    check("runload_no_done", 32'(done_cnt), 32'(d0));
    check("runload_acc_kept", 32'(acc), 32'h03FF);

    // Run held 60 cycles gives exactly one subtraction
    do_load(10'h100);
    d0 = done_cnt;
    do_run(10'h001, 60, {1'b0, 16'h00FF});
    check("held_run_one_done", 32'(done_cnt), 32'(d0 + 1));
    check("held_run_acc", 32'(acc), 32'h00FF);

    // Load pulse and Din changes during SHIFT are ignored
    do_load(10'h3FF);
    @(negedge clk);
    run = 1'b1;
    din = 10'h155;
    exp_q.push_back({1'b0, 16'h02AA});
    exp_cyc_q.push_back(cyc + 18);
    @(negedge clk);
    run = 1'b0;
    din = 10'h2A0;
    check("shift_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    load = 1'b1;
    din  = 10'h001;
    @(negedge clk);
    load = 1'b0;
    din  = 10'h3C3;
    wait_idle("interfere_to_idle");

    // equal operands: result 0, no borrow
    do_load(10'h3FF);
    do_run(10'h3FF, 1, {1'b0, 16'h0000});

    // 0 - 0x10 underflows, leaving Borrow=1 before the reset test
    do_load(10'h000);
    do_run(10'h010, 1, {1'b1, UNDER_0_MINUS_10});

    // Reset 8 cycles into SHIFT discards the subtraction
    d0 = done_cnt;
    @(negedge clk);
    run = 1'b1;
    din = 10'h020;
    @(negedge clk);
    run = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_acc", 32'(acc), 32'd0);
    check("midreset_borrow", 32'(borrow), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_state", 32'(state_dbg), 32'd0);
    repeat (25) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt), 32'(d0));

    // check that subtraction still works after the reset
    do_load(10'h2B7);
    do_run(10'h0A5, 1, {1'b0, 16'h0212});

    repeat (5) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
